// File: rtl/lsu_axi_wr_xbar.sv
// lsu_axi_wr_xbar
//   Write-path AXI4-Lite crossbar: one LSU write master to two write slaves.
//   Accepts a single write at a time (AW and W may arrive in either order).
//   Decodes the captured address and forwards the write to SRAM (s0) or
//   UART (s1). Unmapped addresses get a local DECERR and never reach a slave.
//   The chosen slave's B response is then returned to the master.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   m_aw*, m_w*, m_b*  master AW / W / B channels
//   s0_*               SRAM slave AW / W / B channels
//   s1_*               UART slave AW / W / B channels (2-bit wstrb)
module lsu_axi_wr_xbar #(
    parameter logic [31:0] SRAM_BASE = 32'h8000_0000,
    parameter logic [31:0] SRAM_SIZE = 32'h0800_0000,
    parameter logic [31:0] UART_BASE = 32'hA000_03F8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] m_awaddr,
    input  logic        m_awvalid,
    output logic        m_awready,
    input  logic [31:0] m_wdata,
    input  logic [3:0]  m_wstrb,
    input  logic        m_wvalid,
    output logic        m_wready,
    output logic [1:0]  m_bresp,
    output logic        m_bvalid,
    input  logic        m_bready,
    output logic [31:0] s0_awaddr,
    output logic        s0_awvalid,
    input  logic        s0_awready,
    output logic [31:0] s0_wdata,
    output logic [3:0]  s0_wstrb,
    output logic        s0_wvalid,
    input  logic        s0_wready,
    input  logic [1:0]  s0_bresp,
    input  logic        s0_bvalid,
    output logic        s0_bready,
    output logic [31:0] s1_awaddr,
    output logic        s1_awvalid,
    input  logic        s1_awready,
    output logic [31:0] s1_wdata,
    output logic [1:0]  s1_wstrb,
    output logic        s1_wvalid,
    input  logic        s1_wready,
    input  logic [1:0]  s1_bresp,
    input  logic        s1_bvalid,
    output logic        s1_bready
);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {S_IDLE, S_COLLECT, S_ISSUE, S_WAIT_B, S_RESP} state_t;
    typedef enum logic [1:0] {SEL_NONE, SEL_SRAM, SEL_UART} sel_t;

    // UART wins on overlap; SRAM bound compared in 33 bits so base+size cannot wrap.
    function automatic sel_t decode(input logic [31:0] a);
        logic [32:0] a33, lo, hi;
        a33 = {1'b0, a};
        lo  = {1'b0, SRAM_BASE};
        hi  = {1'b0, SRAM_BASE} + {1'b0, SRAM_SIZE};
        if (a[31:3] == UART_BASE[31:3]) return SEL_UART;
        else if (a33 >= lo && a33 < hi) return SEL_SRAM;
        else return SEL_NONE;
    endfunction

    state_t      state_q, state_d;
    sel_t        sel_q, sel_d;
    logic [31:0] addr_q, addr_d, data_q, data_d;
    logic [3:0]  strb_q, strb_d;
    logic [1:0]  resp_q, resp_d;
    logic        aw_got_q, aw_got_d, w_got_q, w_got_d;
    logic        aw_done_q, aw_done_d, w_done_q, w_done_d;

    logic is_s0, is_s1, issuing, sl_awready, sl_wready, sl_bvalid;
    logic [1:0] sl_bresp;
    logic m_aw_hs, m_w_hs, sl_aw_hs, sl_w_hs;

    assign is_s0   = (sel_q == SEL_SRAM);
    assign is_s1   = (sel_q == SEL_UART);
    assign issuing = (state_q == S_ISSUE);

    // Master readies: both open in IDLE, only the missing one in COLLECT.
    assign m_awready = (state_q == S_IDLE) || (state_q == S_COLLECT && !aw_got_q);
    assign m_wready  = (state_q == S_IDLE) || (state_q == S_COLLECT && !w_got_q);
    assign m_bvalid  = (state_q == S_RESP);
    assign m_bresp   = m_bvalid ? resp_q : RESP_OKAY;

    // Payload comes straight from the capture registers, so it is stable for the whole issue.
    assign s0_awaddr  = addr_q;
    assign s0_wdata   = data_q;
    assign s0_wstrb   = strb_q;
    assign s1_awaddr  = addr_q;
    assign s1_wdata   = data_q;
    assign s1_wstrb   = strb_q[1:0];
    assign s0_awvalid = issuing && is_s0 && !aw_done_q;
    assign s0_wvalid  = issuing && is_s0 && !w_done_q;
    assign s1_awvalid = issuing && is_s1 && !aw_done_q;
    assign s1_wvalid  = issuing && is_s1 && !w_done_q;
    assign s0_bready  = (state_q == S_WAIT_B) && is_s0;
    assign s1_bready  = (state_q == S_WAIT_B) && is_s1;

    assign sl_awready = is_s0 ? s0_awready : s1_awready;
    assign sl_wready  = is_s0 ? s0_wready  : s1_wready;
    assign sl_bvalid  = is_s0 ? s0_bvalid  : s1_bvalid;
    assign sl_bresp   = is_s0 ? s0_bresp   : s1_bresp;

    assign m_aw_hs  = m_awvalid && m_awready;
    assign m_w_hs   = m_wvalid && m_wready;
    assign sl_aw_hs = issuing && !aw_done_q && sl_awready;
    assign sl_w_hs  = issuing && !w_done_q && sl_wready;

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        addr_d    = addr_q;
        data_d    = data_q;
        strb_d    = strb_q;
        resp_d    = resp_q;
        aw_got_d  = aw_got_q;
        w_got_d   = w_got_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        case (state_q)
            S_IDLE, S_COLLECT: begin
                if (m_aw_hs) begin
                    addr_d   = m_awaddr;
                    aw_got_d = 1'b1;
                end
                if (m_w_hs) begin
                    data_d  = m_wdata;
                    strb_d  = m_wstrb;
                    w_got_d = 1'b1;
                end
                // Decode the address being captured this cycle, or the held one.
                sel_d = decode(addr_d);
                if (aw_got_d && w_got_d) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    if (sel_d == SEL_NONE) begin
                        resp_d  = RESP_DECERR;
                        state_d = S_RESP;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end else if (aw_got_d || w_got_d) begin
                    state_d = S_COLLECT;
                end
            end
            S_ISSUE: begin
                aw_done_d = aw_done_q || sl_aw_hs;
                w_done_d  = w_done_q || sl_w_hs;
                if (aw_done_d && w_done_d) state_d = S_WAIT_B;
            end
            S_WAIT_B: begin
                if (sl_bvalid) begin
                    resp_d  = sl_bresp;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (m_bready) begin
                    aw_got_d  = 1'b0;
                    w_got_d   = 1'b0;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            sel_q     <= SEL_NONE;
            addr_q    <= '0;
            data_q    <= '0;
            strb_q    <= '0;
            resp_q    <= RESP_OKAY;
            aw_got_q  <= 1'b0;
            w_got_q   <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            strb_q    <= strb_d;
            resp_q    <= resp_d;
            aw_got_q  <= aw_got_d;
            w_got_q   <= w_got_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end
endmodule

// File: tb/tb_lsu_axi_wr_xbar.sv
// Directed bench for lsu_axi_wr_xbar: table of single writes plus hand-written
// sequences for slave AW stall, master B backpressure and reset mid-transaction.
module tb_lsu_axi_wr_xbar;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] m_awaddr, m_wdata;
    logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
    logic [3:0]  m_wstrb;
    logic [1:0]  m_bresp;
    logic [31:0] s0_awaddr, s0_wdata, s1_awaddr, s1_wdata;
    logic        s0_awvalid, s0_awready, s0_wvalid, s0_wready, s0_bvalid, s0_bready;
    logic        s1_awvalid, s1_awready, s1_wvalid, s1_wready, s1_bvalid, s1_bready;
    logic [3:0]  s0_wstrb;
    logic [1:0]  s1_wstrb, s0_bresp, s1_bresp;

    int n_pass = 0, n_chk = 0;

    always #5 clk = ~clk;

    lsu_axi_wr_xbar dut (
        .clk(clk), .rst(rst),
        .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .s0_awaddr(s0_awaddr), .s0_awvalid(s0_awvalid), .s0_awready(s0_awready),
        .s0_wdata(s0_wdata), .s0_wstrb(s0_wstrb), .s0_wvalid(s0_wvalid), .s0_wready(s0_wready),
        .s0_bresp(s0_bresp), .s0_bvalid(s0_bvalid), .s0_bready(s0_bready),
        .s1_awaddr(s1_awaddr), .s1_awvalid(s1_awvalid), .s1_awready(s1_awready),
        .s1_wdata(s1_wdata), .s1_wstrb(s1_wstrb), .s1_wvalid(s1_wvalid), .s1_wready(s1_wready),
        .s1_bresp(s1_bresp), .s1_bvalid(s1_bvalid), .s1_bready(s1_bready)
    );

    // Slave models: capture payload on handshake, raise bvalid right after the
    // last of AW/W is accepted (unless held), drop it on the B handshake.
    logic        s0_aw_seen, s0_w_seen, s1_aw_seen, s1_w_seen, s0_bhold;
    logic [31:0] s0_cap_addr, s0_cap_data, s1_cap_addr, s1_cap_data;
    logic [3:0]  s0_cap_strb;
    logic [1:0]  s1_cap_strb;
    int          s0_vcnt = 0, s1_vcnt = 0;

    always @(posedge clk) begin
        if (s0_awvalid || s0_wvalid) s0_vcnt <= s0_vcnt + 1;
        if (rst) begin
            s0_aw_seen <= 1'b0; s0_w_seen <= 1'b0; s0_bvalid <= 1'b0;
        end else begin
            if (s0_awvalid && s0_awready) s0_cap_addr <= s0_awaddr;
            if (s0_wvalid && s0_wready) begin s0_cap_data <= s0_wdata; s0_cap_strb <= s0_wstrb; end
            if (s0_bvalid && s0_bready) begin
                s0_bvalid <= 1'b0; s0_aw_seen <= 1'b0; s0_w_seen <= 1'b0;
            end else if (!s0_bvalid) begin
                if ((s0_aw_seen || (s0_awvalid && s0_awready)) &&
                    (s0_w_seen || (s0_wvalid && s0_wready)) && !s0_bhold) begin
                    s0_bvalid <= 1'b1; s0_aw_seen <= 1'b0; s0_w_seen <= 1'b0;
                end else begin
                    if (s0_awvalid && s0_awready) s0_aw_seen <= 1'b1;
                    if (s0_wvalid && s0_wready) s0_w_seen <= 1'b1;
                end
            end
        end
    end

    always @(posedge clk) begin
        if (s1_awvalid || s1_wvalid) s1_vcnt <= s1_vcnt + 1;
        if (rst) begin
            s1_aw_seen <= 1'b0; s1_w_seen <= 1'b0; s1_bvalid <= 1'b0;
        end else begin
            if (s1_awvalid && s1_awready) s1_cap_addr <= s1_awaddr;
            if (s1_wvalid && s1_wready) begin s1_cap_data <= s1_wdata; s1_cap_strb <= s1_wstrb; end
            if (s1_bvalid && s1_bready) begin
                s1_bvalid <= 1'b0; s1_aw_seen <= 1'b0; s1_w_seen <= 1'b0;
            end else if (!s1_bvalid) begin
                if ((s1_aw_seen || (s1_awvalid && s1_awready)) &&
                    (s1_w_seen || (s1_wvalid && s1_wready))) begin
                    s1_bvalid <= 1'b1; s1_aw_seen <= 1'b0; s1_w_seen <= 1'b0;
                end else begin
                    if (s1_awvalid && s1_awready) s1_aw_seen <= 1'b1;
                    if (s1_wvalid && s1_wready) s1_w_seen <= 1'b1;
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    // lead > 0: W leads AW by that many cycles; lead < 0: AW leads W.
    task automatic wr_issue(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input int lead);
        logic aw_d, w_d, aw_h, w_h;
        aw_d = 1'b0; w_d = 1'b0;
        m_awaddr = a; m_wdata = d; m_wstrb = s;
        for (int c = 0; c < 50 && !(aw_d && w_d); c++) begin
            m_awvalid = !aw_d && (c >= (lead > 0 ? lead : 0));
            m_wvalid  = !w_d && (c >= (lead < 0 ? -lead : 0));
            if (w_d && !aw_d) chk("collect_wready_low", {31'b0, m_wready}, 32'd0);
            if (aw_d && !w_d) chk("collect_awready_low", {31'b0, m_awready}, 32'd0);
            aw_h = m_awvalid && m_awready;
            w_h  = m_wvalid && m_wready;
            @(posedge clk);
            if (aw_h) aw_d = 1'b1;
            if (w_h) w_d = 1'b1;
            @(negedge clk);
        end
        m_awvalid = 1'b0; m_wvalid = 1'b0;
        if (!(aw_d && w_d)) chk("master_accept_timeout", 32'd0, 32'd1);
    endtask

    // Called at the first negedge after master accept; exp_lat < 0 skips the latency check.
    task automatic wr_finish(input logic [1:0] exp_resp, input int exp_lat);
        int lat;
        lat = 1;
        while (!m_bvalid && lat < 40) begin cyc(); lat++; end
        if (exp_lat >= 0) chk("bvalid_latency", lat, exp_lat);
        chk("m_bresp", {30'b0, m_bresp}, {30'b0, exp_resp});
        m_bready = 1'b1;
        cyc();
        m_bready = 1'b0;
        chk("bvalid_drop", {31'b0, m_bvalid}, 32'd0);
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        int          lead;
        logic [1:0]  sresp;
        int          sel;   // 0 SRAM, 1 UART, 2 none
        logic [1:0]  bresp;
        int          lat;
    } vec_t;

    vec_t vt[9];

    initial begin
        int c0, c1;
        vt[0] = '{32'h8000_0010, 32'hDEAD_BEEF, 4'hF,  0, 2'b00, 0, 2'b00, 3};
        vt[1] = '{32'hA000_03F8, 32'h0000_0041, 4'h1,  2, 2'b00, 1, 2'b00, 3};
        vt[2] = '{32'h9000_0000, 32'h1111_1111, 4'hF,  0, 2'b00, 2, 2'b11, 1};
        vt[3] = '{32'h87FF_FFFC, 32'h2222_2222, 4'h3, -2, 2'b10, 0, 2'b10, 3};
        vt[4] = '{32'h8800_0000, 32'h3333_3333, 4'hF,  1, 2'b00, 2, 2'b11, 1};
        vt[5] = '{32'h7FFF_FFFC, 32'h4444_4444, 4'hF,  0, 2'b00, 2, 2'b11, 1};
        vt[6] = '{32'hA000_03FF, 32'hCAFE_0055, 4'hC, -1, 2'b10, 1, 2'b10, 3};
        vt[7] = '{32'hA000_0400, 32'h5555_5555, 4'hF,  0, 2'b00, 2, 2'b11, 1};
        vt[8] = '{32'hA000_03F0, 32'h6666_6666, 4'hF,  0, 2'b00, 2, 2'b11, 1};

        rst = 1'b1;
        m_awaddr = '0; m_awvalid = 1'b0; m_wdata = '0; m_wstrb = '0; m_wvalid = 1'b0; m_bready = 1'b0;
        s0_awready = 1'b1; s0_wready = 1'b1; s1_awready = 1'b1; s1_wready = 1'b1;
        s0_bresp = 2'b00; s1_bresp = 2'b00; s0_bhold = 1'b0;
        cyc(); cyc();
        rst = 1'b0;

        // Reset state
        chk("rst_awready", {31'b0, m_awready}, 32'd1);
        chk("rst_wready", {31'b0, m_wready}, 32'd1);
        chk("rst_bvalid", {31'b0, m_bvalid}, 32'd0);
        chk("rst_bresp", {30'b0, m_bresp}, 32'd0);
        chk("rst_slave_valids", {28'b0, s0_awvalid, s0_wvalid, s1_awvalid, s1_wvalid}, 32'd0);

        for (int i = 0; i < 9; i++) begin
            s0_bresp = vt[i].sresp;
            s1_bresp = vt[i].sresp;
            c0 = s0_vcnt; c1 = s1_vcnt;
            wr_issue(vt[i].addr, vt[i].data, vt[i].strb, vt[i].lead);
            wr_finish(vt[i].bresp, vt[i].lat);
            if (vt[i].sel == 0) begin
                chk("s0_awaddr", s0_cap_addr, vt[i].addr);
                chk("s0_wdata", s0_cap_data, vt[i].data);
                chk("s0_wstrb", {28'b0, s0_cap_strb}, {28'b0, vt[i].strb});
                chk("s1_untouched", s1_vcnt - c1, 32'd0);
            end else if (vt[i].sel == 1) begin
                chk("s1_awaddr", s1_cap_addr, vt[i].addr);
                chk("s1_wdata", s1_cap_data, vt[i].data);
                chk("s1_wstrb", {30'b0, s1_cap_strb}, {30'b0, vt[i].strb[1:0]});
                chk("s0_untouched", s0_vcnt - c0, 32'd0);
            end else begin
                chk("decerr_no_s0", s0_vcnt - c0, 32'd0);
                chk("decerr_no_s1", s1_vcnt - c1, 32'd0);
            end
        end

        // s0 AW stalled 3 cycles: W goes through at once, AW held with stable address.
        s0_bresp = 2'b00;
        s0_awready = 1'b0;
        wr_issue(32'h8000_0100, 32'h1122_3344, 4'hF, 0);
        for (int i = 0; i < 3; i++) begin
            chk("stall_awvalid", {31'b0, s0_awvalid}, 32'd1);
            chk("stall_awaddr", s0_awaddr, 32'h8000_0100);
            if (i > 0) chk("stall_wvalid_dropped", {31'b0, s0_wvalid}, 32'd0);
            cyc();
        end
        s0_awready = 1'b1;
        wr_finish(2'b00, -1);
        chk("stall_cap_addr", s0_cap_addr, 32'h8000_0100);
        chk("stall_cap_data", s0_cap_data, 32'h1122_3344);

        // Master B backpressure: response held stable, no new accept meanwhile.
        s0_bresp = 2'b10;
        wr_issue(32'h8000_0200, 32'h7777_0000, 4'hF, 0);
        for (int i = 0; i < 10 && !m_bvalid; i++) cyc();
        for (int i = 0; i < 4; i++) begin
            chk("bp_bvalid", {31'b0, m_bvalid}, 32'd1);
            chk("bp_bresp", {30'b0, m_bresp}, 32'd2);
            chk("bp_no_accept", {30'b0, m_awready, m_wready}, 32'd0);
            cyc();
        end
        wr_finish(2'b10, -1);
        chk("bp_accept_after", {30'b0, m_awready, m_wready}, 32'd3);

        // Reset while waiting for B.
        s0_bresp = 2'b00;
        s0_bhold = 1'b1;
        wr_issue(32'h8000_0300, 32'h8888_0000, 4'hF, 0);
        cyc();
        chk("waitb_bready", {31'b0, s0_bready}, 32'd1);
        rst = 1'b1;
        cyc();
        chk("rst_mid_ready", {30'b0, m_awready, m_wready}, 32'd3);
        chk("rst_mid_valids", {26'b0, s0_awvalid, s0_wvalid, s1_awvalid, s1_wvalid, m_bvalid, s0_bready}, 32'd0);
        rst = 1'b0;
        s0_bhold = 1'b0;

        // Recovery write after the abandoned one.
        wr_issue(32'h8000_0400, 32'h9999_0001, 4'hF, 0);
        wr_finish(2'b00, 3);
        chk("recover_cap_data", s0_cap_data, 32'h9999_0001);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
